ysyx_22040088_lsu: RTL and testbench
====================================

YSYX_22040088_LSU -- requirements
Module: ysyx_22040088_lsu

Interface
REQ-001 SHALL have parameter BUS_W, default 64, the memory data width in bits; only 64 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port mem_ena, input, 1, meaning the current instruction is a load or store; held stable while stall=1.
REQ-005 SHALL have port mem_wen, input, 1, meaning store (1) or load (0).
REQ-006 SHALL have port mem_mask, input, 4, a one-hot access size: 0001=8B, 0010=4B, 0100=2B, 1000=1B.
REQ-007 SHALL have port sel_rfres, input, 3; bit1 selects a sign-extended load and bit2 a zero-extended load.
REQ-008 SHALL have port addr, input, 64, the effective address from the ALU.
REQ-009 SHALL have port wdata, input, 64, store data (rs2), right-aligned.
REQ-010 SHALL have port stall, output, 1, which holds the PC and register write while high.
REQ-011 SHALL have port ldata, output, 64, the extended load result, valid while done=1.
REQ-012 SHALL have port done, output, 1, a one-cycle access-completion pulse.
REQ-013 SHALL have port misalign, output, 1, asserted with done when the access was misaligned.
REQ-014 SHALL have ports bus_req_valid, output, 1, and bus_req_ready, input, 1, the request handshake.
REQ-015 SHALL have ports bus_addr, output, 64, 8B-aligned (addr[2:0] zeroed); bus_wen, output, 1; bus_wdata, output, 64, lane-shifted; bus_wstrb, output, 8, byte strobes.
REQ-016 SHALL have ports bus_resp_valid, input, 1, and bus_rdata, input, 64, the response from the memory; writes also receive a response.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT, DONE.
REQ-018 In IDLE with mem_ena=1, SHALL latch addr, wdata, mem_mask, mem_wen and sel_rfres, then go to REQ, or go to DONE if the access is misaligned.
REQ-019 Misaligned SHALL mean an 8B access with addr[2:0]!=0, a 4B access with addr[1:0]!=0, or a 2B access with addr[0]!=0; no bus access is made and misalign=1 in DONE.
REQ-020 In REQ, SHALL assert bus_req_valid with the latched fields held stable; on bus_req_ready=1, SHALL go to WAIT.
REQ-021 In WAIT, on bus_resp_valid=1, SHALL capture bus_rdata (for loads) and go to DONE.
REQ-022 In DONE, SHALL assert done=1 for one cycle, then return to IDLE unconditionally; the next mem_ena is sampled in IDLE.
REQ-023 stall SHALL equal mem_ena AND (state != DONE), combinationally; this gives a minimum latency of 3 cycles from mem_ena to done for a zero-wait bus.
REQ-024 bus_wstrb SHALL be 0xFF, 0x0F, 0x03 or 0x01 for 8B, 4B, 2B and 1B accesses respectively, shifted left by addr[2:0]; bus_wdata SHALL be wdata shifted left by 8*addr[2:0].
REQ-025 ldata SHALL be captured data shifted right by 8*addr[2:0], truncated to the access size, then sign-extended if sel_rfres[1] or zero-extended if sel_rfres[2]; for 8B accesses it SHALL pass through unchanged.
REQ-026 On a store, or when misalign=1, ldata SHALL be 0.
REQ-027 A bus_resp_valid received outside WAIT SHALL be ignored.
REQ-028 A bus_req_ready received outside REQ SHALL be ignored.
REQ-029 SHALL accept mem_mask=0000 with mem_ena=1 as an 8B access; control never produces this combination.

Reset
REQ-030 With rst=1 at a clock edge, SHALL enter IDLE and clear all latched registers.
REQ-031 While rst=1, outputs SHALL be stall=0, done=0, misalign=0, bus_req_valid=0, ldata=0, and all bus_* outputs 0.
REQ-032 A reset asserted during REQ or WAIT SHALL abandon the access; any late response SHALL be ignored per REQ-027.

Structure
REQ-033 The shared package ysyx_22040088_pkg SHALL hold the mem_mask encodings, the sel_rfres bit indices, and the LSU state enum.
REQ-034 Alignment, strobe, shift and extend logic SHALL be a combinational sub-module, ysyx_22040088_lsu_align; the FSM and registers SHALL stay in the top module.

Verification
REQ-035 Case: ld with addr=0x80000010, zero-wait bus, rdata=0x1122334455667788 -> done in cycle 3, ldata=0x1122334455667788, stall high for cycles 0-2.
REQ-036 Case: lb with addr=0x80000003, rdata=0x00000000_80000000 -> bus_addr=0x80000000, ldata=0xFFFFFFFFFFFFFF80; lbu at the same address -> 0x80.
REQ-037 Case: sh with addr=0x80000006, wdata=0xABCD -> bus_wstrb=0xC0, bus_wdata[63:48]=0xABCD, ldata=0.
REQ-038 Case: lw with addr=0x80000002 -> no bus_req_valid, done and misalign high in cycle 1.
REQ-039 Case: bus_req_ready delayed 4 cycles and bus_resp_valid delayed 2 more -> bus fields stable throughout, stall high until done, exactly one done pulse.
REQ-040 Case: rst asserted during WAIT, then a stray bus_resp_valid -> state IDLE, done never asserted, outputs 0.

Source files
------------

// File: rtl/ysyx_22040088_pkg.sv
// Shared LSU definitions: access-size encodings, sel_rfres bit positions,
// the LSU state enum and a mask-to-size decoder.
package ysyx_22040088_pkg;

  localparam logic [3:0] MASK_8B = 4'b0001;
  localparam logic [3:0] MASK_4B = 4'b0010;
  localparam logic [3:0] MASK_2B = 4'b0100;
  localparam logic [3:0] MASK_1B = 4'b1000;

  localparam int SEL_SEXT_BIT = 1;
  localparam int SEL_ZEXT_BIT = 2;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_8B,
    SIZE_4B,
    SIZE_2B,
    SIZE_1B
  } lsu_size_e;

  // An all-zero mask falls through to a doubleword access.
  function automatic lsu_size_e decode_size(input logic [3:0] mask);
    lsu_size_e sz;
    if ((mask & MASK_1B) != 4'b0000)      sz = SIZE_1B;
    else if ((mask & MASK_2B) != 4'b0000) sz = SIZE_2B;
    else if ((mask & MASK_4B) != 4'b0000) sz = SIZE_4B;
    else                                  sz = SIZE_8B;
    return sz;
  endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_align.sv
// Combinational lane logic for the LSU: misalignment detection, store strobe
// and data shifting, and load extraction with sign/zero extension.
module ysyx_22040088_lsu_align
  import ysyx_22040088_pkg::*;
(
  input  logic [2:0]  addr_lo_i,
  input  logic [3:0]  mask_i,
  input  logic        sext_i,
  input  logic        zext_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic        misalign_o,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] ldata_o
);

  lsu_size_e   size;
  logic [5:0]  shamt;
  logic [63:0] rshift;
  logic [7:0]  strbBase;
  logic        signFill;

  always_comb begin
    size       = decode_size(mask_i);
    shamt      = {addr_lo_i, 3'b000};
    rshift     = rdata_i >> shamt;
    signFill   = sext_i & ~zext_i;
    misalign_o = 1'b0;
    strbBase   = 8'h00;
    ldata_o    = '0;
    case (size)
      SIZE_8B: begin
        misalign_o = |addr_lo_i;
        strbBase   = 8'hFF;
        ldata_o    = rdata_i;
      end
      SIZE_4B: begin
        misalign_o = |addr_lo_i[1:0];
        strbBase   = 8'h0F;
        ldata_o    = {{32{signFill & rshift[31]}}, rshift[31:0]};
      end
      SIZE_2B: begin
        misalign_o = addr_lo_i[0];
        strbBase   = 8'h03;
        ldata_o    = {{48{signFill & rshift[15]}}, rshift[15:0]};
      end
      SIZE_1B: begin
        misalign_o = 1'b0;
        strbBase   = 8'h01;
        ldata_o    = {{56{signFill & rshift[7]}}, rshift[7:0]};
      end
      default: begin
        misalign_o = 1'b0;
      end
    endcase
    wstrb_o = strbBase << addr_lo_i;
    wdata_o = wdata_i << shamt;
  end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: latches one access from the pipeline, runs a valid/ready
// request and a response wait on the memory bus, and reports completion.
module ysyx_22040088_lsu
  import ysyx_22040088_pkg::*;
#(
  parameter int BUS_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_ena,
  input  logic               mem_wen,
  input  logic [3:0]         mem_mask,
  input  logic [2:0]         sel_rfres,
  input  logic [63:0]        addr,
  input  logic [BUS_W-1:0]   wdata,
  output logic               stall,
  output logic [BUS_W-1:0]   ldata,
  output logic               done,
  output logic               misalign,
  output logic               bus_req_valid,
  input  logic               bus_req_ready,
  output logic [63:0]        bus_addr,
  output logic               bus_wen,
  output logic [BUS_W-1:0]   bus_wdata,
  output logic [BUS_W/8-1:0] bus_wstrb,
  input  logic               bus_resp_valid,
  input  logic [BUS_W-1:0]   bus_rdata
);

  lsu_state_e       state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic [BUS_W-1:0] wdata_q, wdata_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             wen_q, wen_d;
  logic             sext_q, sext_d;
  logic             zext_q, zext_d;
  logic             misalign_q, misalign_d;

  logic [2:0]       alAddrLo;
  logic [3:0]       alMask;
  logic             alMisalign;
  logic [7:0]       alWstrb;
  logic [63:0]      alWdata;
  logic [63:0]      alLdata;
  logic             unused_sel;

  assign unused_sel = sel_rfres[0];

  // In IDLE the misalignment check must look at the incoming access.
  assign alAddrLo = (state_q == LSU_IDLE) ? addr[2:0] : addr_q[2:0];
  assign alMask   = (state_q == LSU_IDLE) ? mem_mask  : mask_q;

  ysyx_22040088_lsu_align u_align (
    .addr_lo_i  (alAddrLo),
    .mask_i     (alMask),
    .sext_i     (sext_q),
    .zext_i     (zext_q),
    .wdata_i    (wdata_q),
    .rdata_i    (rdata_q),
    .misalign_o (alMisalign),
    .wstrb_o    (alWstrb),
    .wdata_o    (alWdata),
    .ldata_o    (alLdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mask_q     <= '0;
      wen_q      <= 1'b0;
      sext_q     <= 1'b0;
      zext_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      mask_q     <= mask_d;
      wen_q      <= wen_d;
      sext_q     <= sext_d;
      zext_q     <= zext_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mask_d     = mask_q;
    wen_d      = wen_q;
    sext_d     = sext_q;
    zext_d     = zext_q;
    misalign_d = misalign_q;
    case (state_q)
      LSU_IDLE: begin
        if (mem_ena) begin
          addr_d     = addr;
          wdata_d    = wdata;
          rdata_d    = '0;
          mask_d     = mem_mask;
          wen_d      = mem_wen;
          sext_d     = sel_rfres[SEL_SEXT_BIT];
          zext_d     = sel_rfres[SEL_ZEXT_BIT];
          misalign_d = alMisalign;
          state_d    = alMisalign ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (bus_req_ready) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (bus_resp_valid) begin
          if (!wen_q) rdata_d = bus_rdata;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // Every output is forced low while reset is held, whatever the state.
  always_comb begin
    stall         = 1'b0;
    done          = 1'b0;
    misalign      = 1'b0;
    ldata         = '0;
    bus_req_valid = 1'b0;
    bus_addr      = '0;
    bus_wen       = 1'b0;
    bus_wdata     = '0;
    bus_wstrb     = '0;
    if (!rst) begin
      stall = mem_ena & (state_q != LSU_DONE);
      if (state_q == LSU_REQ) begin
        bus_req_valid = 1'b1;
        bus_addr      = {addr_q[63:3], 3'b000};
        bus_wen       = wen_q;
        bus_wdata     = alWdata;
        bus_wstrb     = alWstrb;
      end
      if (state_q == LSU_DONE) begin
        done     = 1'b1;
        misalign = misalign_q;
        if (!wen_q && !misalign_q) ldata = alLdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Directed self-checking bench for the LSU with a hand-driven memory bus.
module tb_ysyx_22040088_lsu;

  logic        clk;
  logic        rst;
  logic        mem_ena;
  logic        mem_wen;
  logic [3:0]  mem_mask;
  logic [2:0]  sel_rfres;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        stall;
  logic [63:0] ldata;
  logic        done;
  logic        misalign;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_addr;
  logic        bus_wen;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_resp_valid;
  logic [63:0] bus_rdata;

  int total;
  int bad;

  logic [63:0] obsLdata;
  logic [63:0] obsBusAddr;
  logic [63:0] obsWdata;
  logic [7:0]  obsWstrb;
  logic        obsWen;
  logic        obsMisalign;
  logic        obsReqSeen;
  int          obsDoneCycle;
  int          obsDoneCount;
  logic [9:0]  obsStall;

  ysyx_22040088_lsu #(.BUS_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_ena        (mem_ena),
    .mem_wen        (mem_wen),
    .mem_mask       (mem_mask),
    .sel_rfres      (sel_rfres),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .ldata          (ldata),
    .done           (done),
    .misalign       (misalign),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_addr       (bus_addr),
    .bus_wen        (bus_wen),
    .bus_wdata      (bus_wdata),
    .bus_wstrb      (bus_wstrb),
    .bus_resp_valid (bus_resp_valid),
    .bus_rdata      (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one access against a zero-wait bus and records what the DUT showed.
  task automatic zero_wait_access(input logic [63:0] a, input logic [63:0] wd,
                                  input logic [3:0] m, input logic we,
                                  input logic [2:0] sel, input logic [63:0] rd);
    logic pend;
    obsLdata = '0; obsBusAddr = '0; obsWdata = '0; obsWstrb = '0; obsWen = 1'b0;
    obsMisalign = 1'b0; obsReqSeen = 1'b0; obsDoneCycle = -1; obsDoneCount = 0;
    obsStall = '0;
    mem_ena = 1'b1; mem_wen = we; mem_mask = m; sel_rfres = sel;
    addr = a; wdata = wd; bus_req_ready = 1'b1; pend = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus_resp_valid = pend;
      bus_rdata      = pend ? rd : 64'h0;
      pend           = 1'b0;
      #1;
      obsStall[cyc] = stall;
      if (bus_req_valid) begin
        obsReqSeen = 1'b1;
        obsBusAddr = bus_addr;
        obsWdata   = bus_wdata;
        obsWstrb   = bus_wstrb;
        obsWen     = bus_wen;
        pend       = 1'b1;
      end
      if (done) begin
        obsDoneCount++;
        if (obsDoneCycle < 0) obsDoneCycle = cyc;
        obsLdata    = ldata;
        obsMisalign = misalign;
        mem_ena     = 1'b0;
      end
      step();
    end
    mem_ena = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0001; sel_rfres = 3'b000;
    addr = 64'h8000_0000; wdata = '0; bus_req_ready = 1'b1; bus_resp_valid = 1'b0;
    bus_rdata = '0;
    step(); step();
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    total++; if (misalign !== 1'b0) begin bad++; $display("[TB] FAIL reset_misalign: got %b want 0", misalign); end
    total++; if (bus_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid: got %b want 0", bus_req_valid); end
    total++; if (ldata !== 64'h0) begin bad++; $display("[TB] FAIL reset_ldata: got %h want 0", ldata); end
    total++; if ({bus_addr, bus_wdata, bus_wstrb, bus_wen} !== 137'h0) begin bad++; $display("[TB] FAIL reset_bus: got addr %h wdata %h wstrb %h wen %b want all 0", bus_addr, bus_wdata, bus_wstrb, bus_wen); end
    mem_ena = 1'b0; bus_req_ready = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_loads();
    zero_wait_access(64'h8000_0010, 64'h0, 4'b0001, 1'b0, 3'b010, 64'h1122334455667788);
    total++; if (obsDoneCycle !== 3) begin bad++; $display("[TB] FAIL ld_done_cycle: got %0d want 3", obsDoneCycle); end
    total++; if (obsLdata !== 64'h1122334455667788) begin bad++; $display("[TB] FAIL ld_ldata: got %h want 1122334455667788", obsLdata); end
    total++; if (obsStall !== 10'b0000000111) begin bad++; $display("[TB] FAIL ld_stall: got %b want 0000000111", obsStall); end
    total++; if (obsBusAddr !== 64'h8000_0010) begin bad++; $display("[TB] FAIL ld_bus_addr: got %h want 80000010", obsBusAddr); end
    total++; if (obsDoneCount !== 1) begin bad++; $display("[TB] FAIL ld_done_count: got %0d want 1", obsDoneCount); end

    zero_wait_access(64'h8000_0003, 64'h0, 4'b1000, 1'b0, 3'b010, 64'h0000_0000_8000_0000);
    total++; if (obsBusAddr !== 64'h8000_0000) begin bad++; $display("[TB] FAIL lb_bus_addr: got %h want 80000000", obsBusAddr); end
    total++; if (obsLdata !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("[TB] FAIL lb_ldata: got %h want ffffffffffffff80", obsLdata); end

    zero_wait_access(64'h8000_0003, 64'h0, 4'b1000, 1'b0, 3'b100, 64'h0000_0000_8000_0000);
    total++; if (obsLdata !== 64'h80) begin bad++; $display("[TB] FAIL lbu_ldata: got %h want 80", obsLdata); end

    zero_wait_access(64'h8000_0004, 64'h0, 4'b0010, 1'b0, 3'b010, 64'h89AB_CDEF_0123_4567);
    total++; if (obsLdata !== 64'hFFFF_FFFF_89AB_CDEF) begin bad++; $display("[TB] FAIL lw_ldata: got %h want ffffffff89abcdef", obsLdata); end

    zero_wait_access(64'h8000_0004, 64'h0, 4'b0010, 1'b0, 3'b100, 64'h89AB_CDEF_0123_4567);
    total++; if (obsLdata !== 64'h0000_0000_89AB_CDEF) begin bad++; $display("[TB] FAIL lwu_ldata: got %h want 0000000089abcdef", obsLdata); end

    zero_wait_access(64'h8000_0002, 64'h0, 4'b0100, 1'b0, 3'b010, 64'h0000_0000_8001_0000);
    total++; if (obsLdata !== 64'hFFFF_FFFF_FFFF_8001) begin bad++; $display("[TB] FAIL lh_ldata: got %h want ffffffffffff8001", obsLdata); end

    zero_wait_access(64'h8000_0018, 64'h0, 4'b0000, 1'b0, 3'b010, 64'hCAFE_BABE_DEAD_BEEF);
    total++; if (obsLdata !== 64'hCAFE_BABE_DEAD_BEEF) begin bad++; $display("[TB] FAIL mask0_ldata: got %h want cafebabedeadbeef", obsLdata); end
  endtask

  task automatic test_stores();
    zero_wait_access(64'h8000_0006, 64'hABCD, 4'b0100, 1'b1, 3'b000, 64'h5555_5555_5555_5555);
    total++; if (obsWstrb !== 8'hC0) begin bad++; $display("[TB] FAIL sh_wstrb: got %h want c0", obsWstrb); end
    total++; if (obsWdata !== 64'hABCD_0000_0000_0000) begin bad++; $display("[TB] FAIL sh_wdata: got %h want abcd000000000000", obsWdata); end
    total++; if (obsWen !== 1'b1) begin bad++; $display("[TB] FAIL sh_wen: got %b want 1", obsWen); end
    total++; if (obsLdata !== 64'h0) begin bad++; $display("[TB] FAIL sh_ldata: got %h want 0", obsLdata); end
    total++; if (obsDoneCycle !== 3) begin bad++; $display("[TB] FAIL sh_done_cycle: got %0d want 3", obsDoneCycle); end

    zero_wait_access(64'h8000_0008, 64'h0102_0304_0506_0708, 4'b0001, 1'b1, 3'b000, 64'h0);
    total++; if (obsWstrb !== 8'hFF) begin bad++; $display("[TB] FAIL sd_wstrb: got %h want ff", obsWstrb); end
    total++; if (obsWdata !== 64'h0102_0304_0506_0708) begin bad++; $display("[TB] FAIL sd_wdata: got %h want 0102030405060708", obsWdata); end

    zero_wait_access(64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 4'b0010, 1'b1, 3'b000, 64'h0);
    total++; if (obsWstrb !== 8'hF0) begin bad++; $display("[TB] FAIL sw_wstrb: got %h want f0", obsWstrb); end
    total++; if (obsWdata !== 64'hDEAD_BEEF_0000_0000) begin bad++; $display("[TB] FAIL sw_wdata: got %h want deadbeef00000000", obsWdata); end
  endtask

  task automatic test_misalign();
    zero_wait_access(64'h8000_0002, 64'h0, 4'b0010, 1'b0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF);
    total++; if (obsReqSeen !== 1'b0) begin bad++; $display("[TB] FAIL lw_mis_req: got %b want 0", obsReqSeen); end
    total++; if (obsDoneCycle !== 1) begin bad++; $display("[TB] FAIL lw_mis_done_cycle: got %0d want 1", obsDoneCycle); end
    total++; if (obsMisalign !== 1'b1) begin bad++; $display("[TB] FAIL lw_mis_flag: got %b want 1", obsMisalign); end
    total++; if (obsLdata !== 64'h0) begin bad++; $display("[TB] FAIL lw_mis_ldata: got %h want 0", obsLdata); end
    total++; if (obsStall !== 10'b0000000001) begin bad++; $display("[TB] FAIL lw_mis_stall: got %b want 0000000001", obsStall); end

    zero_wait_access(64'h8000_0004, 64'h1234, 4'b0001, 1'b1, 3'b000, 64'h0);
    total++; if ({obsReqSeen, obsMisalign} !== 2'b01) begin bad++; $display("[TB] FAIL sd_mis: got req %b mis %b want req 0 mis 1", obsReqSeen, obsMisalign); end

    zero_wait_access(64'h8000_0001, 64'h0, 4'b0100, 1'b0, 3'b010, 64'h0);
    total++; if ({obsReqSeen, obsMisalign} !== 2'b01) begin bad++; $display("[TB] FAIL lh_mis: got req %b mis %b want req 0 mis 1", obsReqSeen, obsMisalign); end

    zero_wait_access(64'h8000_0001, 64'h0, 4'b1000, 1'b0, 3'b100, 64'h0000_0000_0000_AB00);
    total++; if ({obsMisalign, obsLdata} !== {1'b0, 64'hAB}) begin bad++; $display("[TB] FAIL lbu_odd: got mis %b ldata %h want mis 0 ldata ab", obsMisalign, obsLdata); end

    zero_wait_access(64'h8000_0001, 64'h0, 4'b0000, 1'b0, 3'b010, 64'h0);
    total++; if ({obsReqSeen, obsMisalign} !== 2'b01) begin bad++; $display("[TB] FAIL mask0_mis: got req %b mis %b want req 0 mis 1", obsReqSeen, obsMisalign); end
  endtask

  task automatic test_wait_states();
    logic [14:0] stallBits;
    int reqCycles, fieldBad, doneCount, doneCycle;
    stallBits = '0; reqCycles = 0; fieldBad = 0; doneCount = 0; doneCycle = -1;
    mem_ena = 1'b1; mem_wen = 1'b1; mem_mask = 4'b0010; sel_rfres = 3'b000;
    addr = 64'h8000_0024; wdata = 64'h1234_5678;
    for (int cyc = 0; cyc < 15; cyc++) begin
      bus_req_ready  = (cyc == 5);
      bus_resp_valid = (cyc == 2) || (cyc == 8);
      #1;
      stallBits[cyc] = stall;
      if (bus_req_valid) begin
        reqCycles++;
        if (bus_addr !== 64'h8000_0020 || bus_wstrb !== 8'hF0 ||
            bus_wdata !== 64'h1234_5678_0000_0000 || bus_wen !== 1'b1) fieldBad++;
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
        mem_ena = 1'b0;
      end
      step();
    end
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    total++; if (reqCycles !== 5) begin bad++; $display("[TB] FAIL wait_req_cycles: got %0d want 5", reqCycles); end
    total++; if (fieldBad !== 0) begin bad++; $display("[TB] FAIL wait_fields: got %0d unstable cycles want 0", fieldBad); end
    total++; if (stallBits !== 15'h01FF) begin bad++; $display("[TB] FAIL wait_stall: got %h want 01ff", stallBits); end
    total++; if (doneCycle !== 9) begin bad++; $display("[TB] FAIL wait_done_cycle: got %0d want 9", doneCycle); end
    total++; if (doneCount !== 1) begin bad++; $display("[TB] FAIL wait_done_count: got %0d want 1", doneCount); end
  endtask

  task automatic test_reset_mid();
    int doneCount, ldataNz;
    doneCount = 0; ldataNz = 0;
    mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0001; sel_rfres = 3'b010;
    addr = 64'h8000_0030; wdata = '0; bus_req_ready = 1'b1;
    step();
    total++; if (bus_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL rmid_req: got %b want 1", bus_req_valid); end
    step();
    rst = 1'b1;
    #1;
    total++; if ({stall, done, misalign, bus_req_valid} !== 4'b0000) begin bad++; $display("[TB] FAIL rmid_ctrl: got %b want 0000", {stall, done, misalign, bus_req_valid}); end
    total++; if ({ldata, bus_addr} !== 128'h0) begin bad++; $display("[TB] FAIL rmid_data: got ldata %h addr %h want 0", ldata, bus_addr); end
    step();
    rst = 1'b0; mem_ena = 1'b0; bus_req_ready = 1'b0;
    bus_resp_valid = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      if (done) doneCount++;
      if (ldata !== 64'h0) ldataNz++;
      step();
      bus_resp_valid = 1'b0;
    end
    total++; if (doneCount !== 0) begin bad++; $display("[TB] FAIL rmid_stray_done: got %0d want 0", doneCount); end
    total++; if (ldataNz !== 0) begin bad++; $display("[TB] FAIL rmid_stray_ldata: got %0d nonzero cycles want 0", ldataNz); end
    zero_wait_access(64'h8000_0038, 64'h0, 4'b0001, 1'b0, 3'b010, 64'h0123_4567_89AB_CDEF);
    total++; if (obsDoneCycle !== 3) begin bad++; $display("[TB] FAIL rmid_next_cycle: got %0d want 3", obsDoneCycle); end
    total++; if (obsLdata !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("[TB] FAIL rmid_next_ldata: got %h want 0123456789abcdef", obsLdata); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_wait_states();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
